// File: rtl/unsigned_mac_pipe.sv
// unsigned_mac_pipe: pipelined multiply-accumulate built around UnsignedMultiplier.
// A stream of operand pairs (A,B) is reduced to one dot-product result per
// vector; in_last marks the final pair of each vector.
// Ports:
//   clk, rst              rising-edge clock, async active-high reset
//   in_valid/in_ready     operand-pair handshake (in_ready is combinational)
//   in_last, A, B         last-element flag and unsigned operands
//   out_valid/out_ready   result handshake
//   Sum, Ovf, Cnt         accumulated sum, sticky overflow, element count

// Combinational unsigned multiplier: P = A*B, full n+m bit product.
module UnsignedMultiplier #(
  parameter int unsigned n = 4,
  parameter int unsigned m = 4
) (
  input  logic [n-1:0]   A,
  input  logic [m-1:0]   B,
  output logic [n+m-1:0] P
);
  assign P = (n+m)'(A) * (n+m)'(B);
endmodule

module unsigned_mac_pipe #(
  parameter int unsigned n     = 4,
  parameter int unsigned m     = 4,
  parameter int unsigned ACC_W = 12,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [n-1:0]     A,
  input  logic [m-1:0]     B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] Sum,
  output logic             Ovf,
  output logic [CNT_W-1:0] Cnt
);

  localparam int unsigned P_W = n + m;

  logic             stall;
  logic             accept;
  logic [n-1:0]     a_r;
  logic [m-1:0]     b_r;
  logic             v1;
  logic             last1;
  logic [P_W-1:0]   prod;
  logic [ACC_W-1:0] p_r;
  logic             v2;
  logic             last2;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W:0]   sum_ext;

  // A result waiting on the consumer freezes the whole pipeline.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;

  UnsignedMultiplier #(.n(n), .m(m)) u_mult (
    .A (a_r),
    .B (b_r),
    .P (prod)
  );

  // One extra bit captures the carry-out used for the sticky overflow.
  assign sum_ext = {1'b0, acc} + {1'b0, p_r};

  // Operand, product and accumulator pipeline plus output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      v1        <= 1'b0;
      last1     <= 1'b0;
      p_r       <= '0;
      v2        <= 1'b0;
      last2     <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Ovf       <= 1'b0;
      Cnt       <= '0;
    end else if (!stall) begin
      v1 <= accept;
      if (accept) begin
        a_r   <= A;
        b_r   <= B;
        last1 <= in_last;
      end

      p_r   <= ACC_W'(prod);
      v2    <= v1;
      last2 <= last1;

      if (v2 && last2) begin
        // Close the vector: publish result and restart the accumulation.
        Sum       <= sum_ext[ACC_W-1:0];
        Ovf       <= ovf | sum_ext[ACC_W];
        Cnt       <= cnt + CNT_W'(1);
        out_valid <= 1'b1;
        acc       <= '0;
        ovf       <= 1'b0;
        cnt       <= '0;
      end else begin
        if (v2) begin
          acc <= sum_ext[ACC_W-1:0];
          ovf <= ovf | sum_ext[ACC_W];
          cnt <= cnt + CNT_W'(1);
        end
        // Not stalled implies out_ready is high, so a held result is consumed.
        if (out_valid) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/unsigned_mac_pipe.md
Name: unsigned_mac_pipe

Overview:
- Pipelined multiply-accumulate stage that consumes the product of the existing combinational UnsignedMultiplier (parameters n, m; P = A*B, width n+m).
- Wraps the multiplier with an operand register, a product register and an accumulator, so a stream of operand pairs becomes one dot-product result per vector.
- Valid/ready handshakes on both sides; the input stream marks the last element of each vector.

Parameters:
n, 4, width of operand A (passed to UnsignedMultiplier)
m, 4, width of operand B (passed to UnsignedMultiplier)
ACC_W, 12, accumulator/result width; legal range ACC_W >= n+m
CNT_W, 4, width of element counter

Ports:
clk  input  1  sole clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operand pair
in_last  input  1  pair is last element of current vector
A  input  n  unsigned operand
B  input  m  unsigned operand
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
Sum  output  ACC_W  accumulated sum of vector, mod 2^ACC_W
Ovf  output  1  accumulation of this vector exceeded 2^ACC_W-1
Cnt  output  CNT_W  number of elements in vector, mod 2^CNT_W

Behaviour:
- Reset (async, immediate): out_valid=0, Sum=0, Ovf=0, Cnt=0; all internal valid bits, accumulator, sticky overflow and element counter cleared; any partial vector is discarded. in_ready=1 while rst is low and no stall.
- stall = out_valid & ~out_ready. in_ready = ~stall, combinational.
- While stall is high, every pipeline register, the accumulator and the counters hold.
- Stage 1, accept: the pair is accepted on an edge with in_valid & in_ready. It registers A_r, B_r, last1 and v1=1. On an edge without stall and without accept, v1 is set to 0.
- Multiplier: combinational on A_r, B_r. The product is zero-extended to ACC_W.
- Stage 2: on an edge without stall, P_r <= product, v2 <= v1, last2 <= last1.
- Accumulate, on an edge without stall with v2=1:
  - If last2=0: acc <= acc+P_r (mod 2^ACC_W); ovf <= ovf | carry-out; cnt <= cnt+1.
  - If last2=1: Sum <= acc+P_r; Ovf <= ovf | carry-out; Cnt <= cnt+1; out_valid <= 1; then acc, ovf, cnt all <= 0.
- Output register:
  - out_valid clears on an edge with out_valid & out_ready, unless a new last2 result loads on that same edge; in that case out_valid stays 1 and Sum/Ovf/Cnt take the new values.
  - Sum/Ovf/Cnt are stable while out_valid & ~out_ready.
- Latency: counting the accepting edge of a last element as edge 1, out_valid is high after edge 3.
- Throughput: one pair per cycle with out_ready=1. Single-element vectors produce back-to-back results on consecutive cycles.
- Bubbles (in_valid=0) between elements of a vector do not disturb the accumulation.
- The Cnt wrap at 2^CNT_W is silent; no flag is raised.
- Edge cases:
  - in_last=1 on the very first element gives a one-element vector.
  - A=0 or B=0 contributes 0 but still increments cnt.

Test Plan:
- Single element: A=15, B=15, in_last=1, out_ready=1 -> after edge 3, out_valid=1, Sum=225, Ovf=0, Cnt=1; out_valid=0 next cycle.
- Vector of 3 pairs (3,4),(5,6),(7,8), last on third, back-to-back -> one result: Sum=98, Cnt=3, Ovf=0.
- Overflow with ACC_W=8: two pairs (15,15),(15,15) -> Sum=194 (450 mod 256), Ovf=1, Cnt=2. The following vector (1,1) gives Sum=1, Ovf=0.
- Backpressure: out_ready=0, send three one-element vectors (2,3),(4,5),(6,7):
  - first result Sum=6 held stable; in_ready drops to 0 while stalled.
  - raising out_ready delivers Sum=6, 20, 42 in order, with none lost or duplicated.
- Reset mid-vector: accept (9,9) and (9,9) without last, pulse rst asynchronously between edges -> outputs 0 immediately. Then the vector (1,2) with last gives Sum=2, Cnt=1.
- Bubbles: pairs (1,1), gap of 2 cycles, (2,2), gap, (3,3) last -> Sum=14, Cnt=3.
